// File: rtl/src_window_fetch.sv
// Bilinear upscaler front end: maps an output coordinate to source space and
// fetches the 2x2 source neighbourhood with its fractional weights.
module src_window_fetch #(
    parameter int H_in    = 256,
    parameter int W_in    = 256,
    parameter int H_out   = 512,
    parameter int W_out   = 512,
    parameter int CHANNEL = 3,
    parameter int PIX_W   = 8,
    parameter int FRAC    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [$clog2(W_out)-1:0]      req_x,
    input  logic [$clog2(H_out)-1:0]      req_y,
    output logic                          mem_rd_en,
    output logic [$clog2(H_in*W_in)-1:0]  mem_addr,
    input  logic [CHANNEL*PIX_W-1:0]      mem_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CHANNEL*PIX_W-1:0]      p00,
    output logic [CHANNEL*PIX_W-1:0]      p01,
    output logic [CHANNEL*PIX_W-1:0]      p10,
    output logic [CHANNEL*PIX_W-1:0]      p11,
    output logic [FRAC-1:0]               fx,
    output logic [FRAC-1:0]               fy
);

    localparam int XW     = $clog2(W_out);
    localparam int YW     = $clog2(H_out);
    localparam int AW     = $clog2(H_in*W_in);
    localparam int X0W    = $clog2(W_in);
    localparam int Y0W    = $clog2(H_in);
    localparam int STEP_X = (W_in << FRAC) / W_out;
    localparam int STEP_Y = (H_in << FRAC) / H_out;
    localparam int SXW    = XW + FRAC + 1;
    localparam int SYW    = YW + FRAC + 1;

    localparam logic [XW-1:0]  X_MAX  = XW'(W_out - 1);
    localparam logic [YW-1:0]  Y_MAX  = YW'(H_out - 1);
    localparam logic [X0W-1:0] X0_MAX = X0W'(W_in - 1);
    localparam logic [Y0W-1:0] Y0_MAX = Y0W'(H_in - 1);

    typedef enum logic [2:0] {IDLE, CALC, RD00, RD01, RD10, RD11, CAP, OUT} state_t;

    state_t r_state, w_next;

    logic [XW-1:0]            r_req_x;
    logic [YW-1:0]            r_req_y;
    logic [X0W-1:0]           r_x0, r_x1;
    logic [Y0W-1:0]           r_y0, r_y1;
    logic [FRAC-1:0]          r_fx, r_fy;
    logic [CHANNEL*PIX_W-1:0] r_p00, r_p01, r_p10, r_p11;

    logic [XW-1:0]       w_cx;
    logic [YW-1:0]       w_cy;
    logic [SXW-1:0]      w_sx;
    logic [SYW-1:0]      w_sy;
    logic [SXW-FRAC-1:0] w_x0_full;
    logic [SYW-FRAC-1:0] w_y0_full;
    logic [X0W-1:0]      w_x0, w_x1;
    logic [Y0W-1:0]      w_y0, w_y1;

    function automatic logic [AW-1:0] addr_of(input logic [Y0W-1:0] y, input logic [X0W-1:0] x);
        return AW'(y) * AW'(W_in) + AW'(x);
    endfunction

    // Source coordinate math; the full-width product keeps every integer bit.
    always_comb begin
        w_cx      = (r_req_x > X_MAX) ? X_MAX : r_req_x;
        w_cy      = (r_req_y > Y_MAX) ? Y_MAX : r_req_y;
        w_sx      = SXW'(w_cx) * SXW'(STEP_X);
        w_sy      = SYW'(w_cy) * SYW'(STEP_Y);
        w_x0_full = w_sx[SXW-1:FRAC];
        w_y0_full = w_sy[SYW-1:FRAC];
        w_x0      = X0W'(w_x0_full);
        w_y0      = Y0W'(w_y0_full);
        w_x1      = (w_x0 == X0_MAX) ? w_x0 : w_x0 + X0W'(1);
        w_y1      = (w_y0 == Y0_MAX) ? w_y0 : w_y0 + Y0W'(1);
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = CALC;
            end
            CALC: w_next = RD00;
            RD00: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_of(r_y0, r_x0);
                w_next    = RD01;
            end
            RD01: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_of(r_y0, r_x1);
                w_next    = RD10;
            end
            RD10: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_of(r_y1, r_x0);
                w_next    = RD11;
            end
            RD11: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_of(r_y1, r_x1);
                w_next    = CAP;
            end
            CAP: w_next = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_req_x <= '0;
            r_req_y <= '0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_fx    <= '0;
            r_fy    <= '0;
            r_p00   <= '0;
            r_p01   <= '0;
            r_p10   <= '0;
            r_p11   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_req_x <= req_x;
                r_req_y <= req_y;
            end
            if (r_state == CALC) begin
                r_x0 <= w_x0;
                r_x1 <= w_x1;
                r_y0 <= w_y0;
                r_y1 <= w_y1;
                r_fx <= w_sx[FRAC-1:0];
                r_fy <= w_sy[FRAC-1:0];
            end
            // Read data trails its strobe by one cycle, hence the offset capture.
            case (r_state)
                RD01:    r_p00 <= mem_rdata;
                RD10:    r_p01 <= mem_rdata;
                RD11:    r_p10 <= mem_rdata;
                CAP:     r_p11 <= mem_rdata;
                default: ;
            endcase
        end
    end

    assign p00 = r_p00;
    assign p01 = r_p01;
    assign p10 = r_p10;
    assign p11 = r_p11;
    assign fx  = r_fx;
    assign fy  = r_fy;

endmodule

// File: tb/tb_src_window_fetch.sv
// Scoreboard bench for src_window_fetch: a driver queues expected reads and
// neighbourhoods from an arithmetic model; negedge monitors compare.
module tb_src_window_fetch;

    localparam int H_IN = 256, W_IN = 256, H_OUT = 512, W_OUT = 512;
    localparam int CH = 3, PW = 8, FR = 8;
    localparam int STEP_X = (W_IN * 256) / W_OUT;
    localparam int STEP_Y = (H_IN * 256) / H_OUT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_x = '0;
    logic [8:0]  req_y = '0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [23:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] p00, p01, p10, p11;
    logic [7:0]  fx, fy;

    typedef struct {
        logic [23:0] p00, p01, p10, p11;
        logic [7:0]  fx, fy;
    } exp_t;

    exp_t        exq[$];
    logic [15:0] adq[$];
    int          acq[$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int last_pop = -1;
    bit seen_valid = 0;
    bit b2b_mode = 0;
    bit rand_mode = 0;

    src_window_fetch #(
        .H_in(H_IN), .W_in(W_IN), .H_out(H_OUT), .W_out(W_OUT),
        .CHANNEL(CH), .PIX_W(PW), .FRAC(FR)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .fx(fx), .fy(fy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] memf(input int a);
        logic [15:0] b;
        b = 16'(a);
        return {b[7:0], b[15:8], ~b[7:0]};
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rdata <= memf(int'(mem_addr));

    always @(posedge clk) if (rand_mode) begin
        #1 out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: source coordinate = out coordinate * step, split into integer and fraction.
    task automatic push_exp(input int x, input int y);
        int cx, cy, sx, sy, x0, x1, y0, y1;
        exp_t e;
        cx = (x > W_OUT - 1) ? W_OUT - 1 : x;
        cy = (y > H_OUT - 1) ? H_OUT - 1 : y;
        sx = cx * STEP_X;
        sy = cy * STEP_Y;
        x0 = sx / 256;
        y0 = sy / 256;
        x1 = (x0 + 1 > W_IN - 1) ? W_IN - 1 : x0 + 1;
        y1 = (y0 + 1 > H_IN - 1) ? H_IN - 1 : y0 + 1;
        adq.push_back(16'(y0 * W_IN + x0));
        adq.push_back(16'(y0 * W_IN + x1));
        adq.push_back(16'(y1 * W_IN + x0));
        adq.push_back(16'(y1 * W_IN + x1));
        e.p00 = memf(y0 * W_IN + x0);
        e.p01 = memf(y0 * W_IN + x1);
        e.p10 = memf(y1 * W_IN + x0);
        e.p11 = memf(y1 * W_IN + x1);
        e.fx  = 8'(sx % 256);
        e.fy  = 8'(sy % 256);
        exq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (mem_rd_en) begin
                if (adq.size() == 0) fail_now("unexpected_read");
                else check("mem_addr", 32'(mem_addr), 32'(adq.pop_front()));
            end
            if (out_valid) begin
                if (exq.size() == 0) fail_now("unexpected_out_valid");
                else begin
                    if (!seen_valid) begin
                        seen_valid = 1;
                        if (acq.size() != 0) check("latency", 32'(cyc - acq[0]), 32'd6);
                    end
                    check("p00", 32'(p00), 32'(exq[0].p00));
                    check("p01", 32'(p01), 32'(exq[0].p01));
                    check("p10", 32'(p10), 32'(exq[0].p10));
                    check("p11", 32'(p11), 32'(exq[0].p11));
                    check("fx", 32'(fx), 32'(exq[0].fx));
                    check("fy", 32'(fy), 32'(exq[0].fy));
                    if (out_ready) begin
                        if (b2b_mode && last_pop >= 0) check("spacing", 32'(cyc - last_pop), 32'd8);
                        last_pop = cyc;
                        void'(exq.pop_front());
                        if (acq.size() != 0) void'(acq.pop_front());
                        seen_valid = 0;
                    end
                end
            end
        end
    end

    task automatic issue(input int x, input int y);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            fail_now("req_ready_timeout");
        end else begin
            req_x     = 9'(x);
            req_y     = 9'(y);
            req_valid = 1'b1;
            @(posedge clk);
            push_exp(x, y);
            #1;
            last_acc = cyc;
            acq.push_back(cyc);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exq.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (exq.size() != 0) fail_now("drain_timeout");
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_pix"}, 32'(p00 | p01 | p10 | p11), 32'd0);
        check({tag, "_frac"}, 32'({fx, fy}), 32'd0);
    endtask

    initial begin
        int n, rc;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 0);
        drain();
        issue(3, 5);
        drain();
        issue(511, 511);
        drain();

        // Backpressure: hold the neighbourhood in OUT for ten cycles.
        out_ready = 1'b0;
        issue(10, 20);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
        repeat (10) begin
            @(negedge clk);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_mem_rd_en", 32'(mem_rd_en), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rc = cyc;
        issue(6, 7);
        check("accept_gap", 32'(last_acc - rc), 32'd2);
        drain();

        // Reset pulse while the second read is on the bus.
        issue(4, 4);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exq.delete();
        adq.delete();
        acq.delete();
        seen_valid = 0;
        check_idle_zero("midreset");
        rst = 1'b1;
        issue(2, 2);
        drain();

        b2b_mode = 1;
        last_pop = -1;
        for (int i = 0; i < 16; i++) issue(i, 0);
        drain();
        b2b_mode = 0;

        rand_mode = 1;
        for (int i = 0; i < 40; i++) issue(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
        rand_mode = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        check("addr_queue_empty", 32'(adq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/src_window_fetch.md
Name: src_window_fetch

Overview:
- Upstream feeder for the bilinear upscaler datapath.
- Accepts one output-pixel coordinate per request and maps it to fixed-point source coordinates.
- Reads the 2x2 source neighbourhood from single-port source-image RAM (1-cycle read latency).
- Presents the four pixels plus fractional weights to the interpolator over a valid/ready handshake.

Parameters:
- H_in, 256, source image height
- W_in, 256, source image width
- H_out, 512, output image height (H_out >= H_in)
- W_out, 512, output image width (W_out >= W_in)
- CHANNEL, 3, colour channels per pixel
- PIX_W, 8, bits per channel
- FRAC, 8, fractional bits of source coordinate

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-low reset
- req_valid  in  1  coordinate request valid
- req_ready  out  1  block can accept a request
- req_x  in  $clog2(W_out)  output column
- req_y  in  $clog2(H_out)  output row
- mem_rd_en  out  1  source RAM read strobe
- mem_addr  out  $clog2(H_in*W_in)  source RAM address, row-major y*W_in+x
- mem_rdata  in  CHANNEL*PIX_W  read data, valid the cycle after mem_rd_en
- out_valid  out  1  neighbourhood valid
- out_ready  in  1  interpolator accepts
- p00, p01, p10, p11  out  CHANNEL*PIX_W each  pixels (y0,x0), (y0,x1), (y1,x0), (y1,x1)
- fx, fy  out  FRAC each  fractional weights

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE; req_ready=1 (combinational, IDLE only).
  - out_valid=0, mem_rd_en=0, mem_addr=0, p00..p11=0, fx=fy=0.
  - Any in-flight read data is discarded.
  - Applies from any state, including mid-fetch.
- Scale constants, elaboration time:
  - STEP_X=(W_in<<FRAC)/W_out; STEP_Y=(H_in<<FRAC)/H_out.
  - Defaults give 128 (0.5).
- Coordinate math in CALC, registered:
  - sx=req_x*STEP_X at full width, no truncation.
  - x0=sx>>FRAC; fx=sx[FRAC-1:0]; x1=min(x0+1, W_in-1). Same rule for y.
  - req_x >= W_out is clamped to W_out-1 before the multiply; same for req_y.
- FSM: IDLE -> CALC -> RD00 -> RD01 -> RD10 -> RD11 -> CAP -> OUT.
  - IDLE: req_valid&req_ready latches req_x/req_y; next state CALC.
  - RDxx: mem_rd_en=1, mem_addr of that corner.
  - RD01, RD10, RD11, CAP each capture mem_rdata into p00, p01, p10, p11 respectively.
  - Always four reads, even when clamped addresses coincide.
  - OUT: out_valid=1; p*, fx, fy held stable.
    - out_ready=1 -> IDLE.
    - out_ready=0 -> stay in OUT.
  - mem_rd_en=0 in IDLE, CALC, CAP and OUT.
- Latency and throughput:
  - Accepting edge E0; out_valid rises after edge E6.
  - Minimum 8 cycles per neighbourhood with out_ready held high.
- req_ready=0 in every state except IDLE. Requests are not queued.
- out_valid never drops without out_ready=1 at a rising edge.

Test Plan:
- Memory model for all scenarios: mem[a]={a[7:0], a[15:8], ~a[7:0]}; default parameters.
- Request (0,0) -> mem_addr sequence 0,1,256,257 on consecutive cycles; fx=fy=0; p11=mem[257]; out_valid after 6th edge post-accept.
- Request (3,5) -> x0=1, fx=128, y0=2, fy=128; addresses 513,514,769,770; p00=mem[513].
- Corner request (511,511) -> x0=y0=255, fx=fy=128; all four addresses 65535; p00==p01==p10==p11.
- Backpressure: out_ready=0 for 10 cycles in OUT -> outputs stable, req_ready=0, mem_rd_en=0 throughout; accept on release; next request accepted one cycle later.
- Reset pulse (rst=0, one cycle) while in RD01 -> next cycle all outputs zero, req_ready=1; a following request (2,2) completes correctly with addresses 257,258,513,514.
- Back-to-back: 16 requests along row 0 with out_ready=1 -> 16 outputs, each 8 cycles apart, fx alternating 0/128, x0 = 0,0,1,1,...,7,7.
